reorder_issue_arbiter: RTL

//   Shares one reorder queue's tag space among NUM_REQ read requesters.
//   - Round-robin grant; allocates the queue's index_tag; pulses increment.
//   - Forwards the tagged request to memory through a one-entry output stage.
//   - Remembers the source of each tag, so in-order responses leaving the queue
//     are steered back to the right requester.
//   - Holds off all issue while the queue runs its post-reset tag initialisation.

---
 rtl/reorder_issue_arbiter_if.sv | 38 +++
 rtl/reorder_issue_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_issue_arbiter_if.sv
// Signal bundle for reorder_issue_arbiter: requester handshake, reorder-queue tag
// allocation, registered memory request and in-order response steering.
interface reorder_issue_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 48,
    parameter int TAG_WIDTH  = 7,
    parameter int SRC_WIDTH  = 2
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ-1:0]            req_ready;

    logic                          rq_full;
    logic [TAG_WIDTH-1:0]          rq_index_tag;
    logic                          rq_increment;

    logic                          mem_valid;
    logic [ADDR_WIDTH-1:0]         mem_addr;
    logic [TAG_WIDTH-1:0]          mem_tag;
    logic                          mem_stall;

    logic                          rsp_valid;
    logic [TAG_WIDTH-1:0]          rsp_tag;
    logic [SRC_WIDTH-1:0]          rsp_src;
    logic                          rsp_src_vld;

    // Environment side: requesters, reorder queue and memory.
    modport master (
        output req_valid, req_addr, rq_full, rq_index_tag, mem_stall, rsp_valid, rsp_tag,
        input  req_ready, rq_increment, mem_valid, mem_addr, mem_tag, rsp_src, rsp_src_vld
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_addr, rq_full, rq_index_tag, mem_stall, rsp_valid, rsp_tag,
        output req_ready, rq_increment, mem_valid, mem_addr, mem_tag, rsp_src, rsp_src_vld
    );
endinterface

// File: rtl/reorder_issue_arbiter.sv
// Round-robin issue arbiter sharing one reorder queue's tag space among NUM_REQ requesters.
// Optional statistics counters are enabled with `define REORDER_ARB_STATS_EN.
module reorder_issue_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 48,
    parameter int DEPTH      = 64,
    parameter int TAG_WIDTH  = 7,
    parameter int SRC_WIDTH  = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    reorder_issue_arbiter_if.slave    bus
`ifdef REORDER_ARB_STATS_EN
    ,
    output logic [NUM_REQ*32-1:0]     stat_grants,
    output logic [31:0]               stat_full_cyc
`endif
);

    localparam int IDX_WIDTH   = TAG_WIDTH - 1;
    localparam int INIT_CYCLES = DEPTH + 2;
    localparam int CNT_WIDTH   = $clog2(INIT_CYCLES + 1);
    localparam int CAND_WIDTH  = SRC_WIDTH + 1;

    localparam logic [CNT_WIDTH-1:0]  INIT_LAST  = CNT_WIDTH'(INIT_CYCLES - 1);
    localparam logic [CAND_WIDTH-1:0] NUM_REQ_C  = CAND_WIDTH'(NUM_REQ);
    localparam logic [SRC_WIDTH-1:0]  LAST_RESET = SRC_WIDTH'(NUM_REQ - 1);

    typedef enum logic {
        ST_INIT,
        ST_ISSUE
    } state_t;

    state_t                 state, state_nxt;
    logic [CNT_WIDTH-1:0]   init_cnt, init_cnt_nxt;
    logic [SRC_WIDTH-1:0]   last_grant;
    logic [SRC_WIDTH-1:0]   winner;
    logic [CAND_WIDTH-1:0]  cand;
    logic                   found;
    logic                   slot_free;
    logic                   grant;
    logic [NUM_REQ-1:0]     ready_vec;
    logic [ADDR_WIDTH-1:0]  win_addr;

    logic                   mem_valid_q;
    logic [ADDR_WIDTH-1:0]  mem_addr_q;
    logic [TAG_WIDTH-1:0]   mem_tag_q;

    logic [SRC_WIDTH-1:0]   src_tbl [0:DEPTH-1];
    logic [SRC_WIDTH-1:0]   rsp_src_q;
    logic                   rsp_src_vld_q;

    // ------------------------------------------------------------------
    // Init/issue FSM. The counter leaves INIT on the edge where it reaches
    // DEPTH+2, so the first grant can happen in cycle DEPTH+2 after reset.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_INIT;
            init_cnt <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state    <= state_nxt;
            init_cnt <= init_cnt_nxt;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path through this block infers a latch.
        state_nxt    = state;
        init_cnt_nxt = init_cnt;
        case (state)
            ST_INIT: begin
                init_cnt_nxt = init_cnt + 1'b1;
                if (init_cnt == INIT_LAST) begin
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_nxt = ST_ISSUE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Round-robin pick: first valid requester after last_grant, wrapping.
    // ------------------------------------------------------------------
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = {1'b0, last_grant} + CAND_WIDTH'(i);
            if (cand >= NUM_REQ_C) begin
                cand = cand - NUM_REQ_C;
            end
            if (!found && bus.req_valid[cand[SRC_WIDTH-1:0]]) begin
                found  = 1'b1;
                winner = cand[SRC_WIDTH-1:0];
            end
        end
    end

    assign slot_free = !mem_valid_q || !bus.mem_stall;
    assign grant     = (state == ST_ISSUE) && found && !bus.rq_full && slot_free;

    always_comb begin
        ready_vec = '0;
        if (grant) begin
            ready_vec[winner] = 1'b1;
        end
    end

    always_comb begin
        win_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == SRC_WIDTH'(i)) begin
                win_addr = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    assign bus.req_ready    = ready_vec;
    assign bus.rq_increment = grant;

    // ------------------------------------------------------------------
    // One-entry output stage. A grant is only possible when the slot is
    // empty or draining this cycle, so a grant always overwrites safely.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_valid_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_tag_q   <= '0;
            last_grant  <= LAST_RESET;
        end else if (grant) begin
            mem_valid_q <= 1'b1;
            mem_addr_q  <= win_addr;
            mem_tag_q   <= bus.rq_index_tag;
            last_grant  <= winner;
        end else if (mem_valid_q && !bus.mem_stall) begin
            mem_valid_q <= 1'b0;
        end
    end

    assign bus.mem_valid = mem_valid_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_tag   = mem_tag_q;

    // ------------------------------------------------------------------
    // Tag-owner table, indexed without the phase bit.
    // ------------------------------------------------------------------
    // NOTE: the table has no reset; every entry is written at allocation before its response can be read.
    always_ff @(posedge clk) begin
        if (grant) begin
            src_tbl[bus.rq_index_tag[IDX_WIDTH-1:0]] <= winner;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_src_q     <= '0;
            rsp_src_vld_q <= 1'b0;
        end else begin
            rsp_src_q     <= src_tbl[bus.rsp_tag[IDX_WIDTH-1:0]];
            rsp_src_vld_q <= bus.rsp_valid;
        end
    end

    assign bus.rsp_src     = rsp_src_q;
    assign bus.rsp_src_vld = rsp_src_vld_q;

`ifdef REORDER_ARB_STATS_EN
    // ------------------------------------------------------------------
    // Saturating grant and full-stall counters.
    // ------------------------------------------------------------------
    logic [31:0] grant_cnt [NUM_REQ];
    logic [31:0] full_cnt;
    logic        full_block;

    assign full_block = (state == ST_ISSUE) && (|bus.req_valid) && bus.rq_full;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                grant_cnt[i] <= '0;
            end
            full_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant && winner == SRC_WIDTH'(i) && grant_cnt[i] != '1) begin
                    grant_cnt[i] <= grant_cnt[i] + 32'd1;
                end
            end
            if (full_block && full_cnt != '1) begin
                full_cnt <= full_cnt + 32'd1;
            end
        end
    end

    always_comb begin
        stat_grants = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            stat_grants[i*32 +: 32] = grant_cnt[i];
        end
    end

    assign stat_full_cyc = full_cnt;
`endif

    // ------------------------------------------------------------------
    // Interface invariants.
    // ------------------------------------------------------------------
    a_no_inc_when_full : assert property (@(posedge clk) disable iff (!rst)
        bus.rq_full |-> !bus.rq_increment);
    a_ready_onehot0    : assert property (@(posedge clk) disable iff (!rst)
        $onehot0(bus.req_ready));
    a_stall_holds      : assert property (@(posedge clk) disable iff (!rst)
        (mem_valid_q && bus.mem_stall) |=> (mem_valid_q && $stable(mem_addr_q) && $stable(mem_tag_q)));

endmodule
